alu_req_arbiter: RTL and testbench

//  Shares the single 16-bit ALU between four requesters (round-robin arbitration).

---
 rtl/alu_req_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU between four requesters and returns each result.
// Latency: grant one edge after req is sampled in IDLE, done ALU_LAT edges after the grant.
// Backpressure: none; requesters hold req until their done pulse, and other requests wait.
module alu_req_arbiter #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_bus,
  input  logic [4*WIDTH-1:0] b_bus,
  input  logic [15:0]        func_bus,
  input  logic [WIDTH-1:0]   alu_result,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_func,
  output logic               alu_en,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter is 4 bits wide, so ALU_LAT must stay in 1..15.
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic [1:0]         rr_ptr_q;
  logic [1:0]         owner_q;
  logic [WIDTH-1:0]   alu_a_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic [3:0]         alu_func_q;
  logic               alu_en_q;
  logic [3:0]         gnt_q;
  logic [3:0]         done_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;

  logic               win_vld_d;
  logic [1:0]         win_idx_d;
  logic [1:0]         scan_idx;

  // Pick the first pending requester starting at rr_ptr and wrapping mod 4.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr_q + 2'(k);
      if (!win_vld_d && req[scan_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = scan_idx;
      end
    end
  end

  // Control FSM with every output registered; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rr_ptr_q   <= 2'd0;
      owner_q    <= 2'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= 4'd0;
      alu_en_q   <= 1'b0;
      gnt_q      <= 4'd0;
      done_q     <= 4'd0;
      result_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            alu_a_q    <= a_bus[32'(win_idx_d)*WIDTH +: WIDTH];
            alu_b_q    <= b_bus[32'(win_idx_d)*WIDTH +: WIDTH];
            alu_func_q <= func_bus[{win_idx_d, 2'b00} +: 4];
            gnt_q      <= 4'b0001 << win_idx_d;
            owner_q    <= win_idx_d;
            cnt_q      <= LAT_INIT;
            alu_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            result_q <= alu_result;
            done_q   <= gnt_q;
            alu_en_q <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          // The owner drops to lowest priority for the next arbitration.
          gnt_q    <= 4'd0;
          done_q   <= 4'd0;
          busy_q   <= 1'b0;
          rr_ptr_q <= owner_q + 2'd1;
          state_q  <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          gnt_q    <= 4'd0;
          done_q   <= 4'd0;
          alu_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_func = alu_func_q;
  assign alu_en   = alu_en_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign result   = result_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3.
// The LAT=1 instance is checked through a scoreboard of expected (owner, result) pairs.
// The LAT=3 instance is checked cycle by cycle for enable/busy length and reset abort.
module tb_alu_req_arbiter;

  localparam int W = 16;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] res;
  } sb_t;

  logic         clk;
  logic         rst;
  logic [3:0]   req1;
  logic [3:0]   req3;
  logic [4*W-1:0] a_bus;
  logic [4*W-1:0] b_bus;
  logic [15:0]  func_bus;

  logic [W-1:0] alu_res1, u1_a, u1_b, u1_result;
  logic [3:0]   u1_func, u1_gnt, u1_done;
  logic         u1_en, u1_busy;
  logic [W-1:0] alu_res3, u3_a, u3_b, u3_result;
  logic [3:0]   u3_func, u3_gnt, u3_done;
  logic         u3_en, u3_busy;

  int  n_chk;
  int  n_fail;
  sb_t sb_q[$];
  sb_t sb_e;

  // Reference ALU: op in [1:0], unit select folded into the top bits.
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] fn);
    logic [15:0] r;
    case (fn[1:0])
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a & b;
      default: r = a ^ b;
    endcase
    return r ^ {fn[3:2], 14'b0};
  endfunction

  function automatic logic [15:0] slot_res(input int i);
    return alu_f(a_bus[i*W +: W], b_bus[i*W +: W], func_bus[i*4 +: 4]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  assign alu_res1 = alu_f(u1_a, u1_b, u1_func);
  assign alu_res3 = alu_f(u3_a, u3_b, u3_func);

  alu_req_arbiter #(.WIDTH(W), .ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .a_bus(a_bus), .b_bus(b_bus), .func_bus(func_bus),
    .alu_result(alu_res1), .alu_a(u1_a), .alu_b(u1_b), .alu_func(u1_func), .alu_en(u1_en),
    .gnt(u1_gnt), .done(u1_done), .result(u1_result), .busy(u1_busy)
  );

  alu_req_arbiter #(.WIDTH(W), .ALU_LAT(3)) u3 (
    .clk(clk), .rst(rst), .req(req3), .a_bus(a_bus), .b_bus(b_bus), .func_bus(func_bus),
    .alu_result(alu_res3), .alu_a(u3_a), .alu_b(u3_b), .alu_func(u3_func), .alu_en(u3_en),
    .gnt(u3_gnt), .done(u3_done), .result(u3_result), .busy(u3_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard and invariants for the LAT=1 instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_done_subset_gnt", {28'b0, u1_done & ~u1_gnt}, 32'd0);
      chk("inv_gnt_onehot0", {31'b0, $onehot0(u1_gnt)}, 32'd1);
      if (u1_done != 4'd0) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_done", {28'b0, u1_done}, 32'd0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_done_owner", {28'b0, u1_done}, 32'(4'b0001 << sb_e.id));
          chk("sb_result", {16'b0, u1_result}, {16'b0, sb_e.res});
        end
      end
    end
  end

  task automatic set_slot(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f);
    a_bus[i*W +: W]  = a;
    b_bus[i*W +: W]  = b;
    func_bus[i*4 +: 4] = f;
  endtask

  task automatic push(input int i);
    sb_t e;
    e.id  = 2'(i);
    e.res = slot_res(i);
    sb_q.push_back(e);
  endtask

  task automatic wait_gnt1(input logic [3:0] exp, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (u1_gnt == 4'd0 && n < 20);
    chk(tag, {28'b0, u1_gnt}, {28'b0, exp});
  endtask

  task automatic wait_idle1(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (u1_busy && n < 20);
    chk(tag, {31'b0, u1_busy}, 32'd0);
  endtask

  task automatic chk_zero3(input string tag);
    chk({tag, "_gnt"},  {28'b0, u3_gnt}, 32'd0);
    chk({tag, "_done"}, {28'b0, u3_done}, 32'd0);
    chk({tag, "_en"},   {31'b0, u3_en}, 32'd0);
    chk({tag, "_busy"}, {31'b0, u3_busy}, 32'd0);
    chk({tag, "_a"},    {16'b0, u3_a}, 32'd0);
    chk({tag, "_b"},    {16'b0, u3_b}, 32'd0);
    chk({tag, "_func"}, {28'b0, u3_func}, 32'd0);
    chk({tag, "_res"},  {16'b0, u3_result}, 32'd0);
  endtask

  initial begin
    int en_cnt, busy_cnt, done_at, done_cnt;
    logic [15:0] exp3;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    req1   = 4'd0;
    req3   = 4'd0;
    a_bus  = '0;
    b_bus  = '0;
    func_bus = '0;
    set_slot(0, 16'h1234, 16'h0101, 4'h0);
    set_slot(1, 16'h5000, 16'h0123, 4'h5);
    set_slot(2, 16'h0003, 16'h0004, 4'h0);
    set_slot(3, 16'hF0F0, 16'h3C3C, 4'hE);
    repeat (2) @(negedge clk);

    // Reset state of both instances.
    chk_zero3("rst3");
    chk("rst1_gnt", {28'b0, u1_gnt}, 32'd0);
    chk("rst1_busy", {31'b0, u1_busy}, 32'd0);
    chk("rst1_res", {16'b0, u1_result}, 32'd0);
    rst = 1'b0;

    // Test 1: single request, 3 + 4 with ALU_LAT=1.
    @(negedge clk);
    push(2);
    req1 = 4'b0100;
    @(negedge clk);
    chk("t1_gnt", {28'b0, u1_gnt}, 32'h4);
    chk("t1_alu_en", {31'b0, u1_en}, 32'd1);
    chk("t1_alu_a", {16'b0, u1_a}, 32'h3);
    chk("t1_alu_b", {16'b0, u1_b}, 32'h4);
    chk("t1_done_early", {28'b0, u1_done}, 32'd0);
    @(negedge clk);
    chk("t1_done", {28'b0, u1_done}, 32'h4);
    chk("t1_result", {16'b0, u1_result}, 32'h7);
    chk("t1_en_off", {31'b0, u1_en}, 32'd0);
    chk("t1_busy_done", {31'b0, u1_busy}, 32'd1);
    req1 = 4'b0000;
    @(negedge clk);
    chk("t1_idle_busy", {31'b0, u1_busy}, 32'd0);
    chk("t1_idle_gnt", {28'b0, u1_gnt}, 32'd0);
    chk("t1_idle_done", {28'b0, u1_done}, 32'd0);

    // Test 2: all four requesting from a fresh pointer -> 0,1,2,3,0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) push(k % 4);
    req1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt1(4'b0001 << (k % 4), "t2_rr_order");
      if (k == 4) req1 = 4'b0000;
      wait_idle1("t2_idle");
    end

    // Test 6: pointer now at 1; 1001 grants 3 first, then wraps to 0.
    push(3);
    push(0);
    req1 = 4'b1001;
    wait_gnt1(4'b1000, "t6_wrap_first");
    wait_idle1("t6_idle_a");
    wait_gnt1(4'b0001, "t6_wrap_second");
    req1 = 4'b0000;
    wait_idle1("t6_idle_b");

    // Test 5: operands and req changed after grant are ignored.
    push(1);
    req1 = 4'b0010;
    wait_gnt1(4'b0010, "t5_gnt");
    req1 = 4'b0000;
    a_bus[1*W +: W] = 16'hDEAD;
    wait_idle1("t5_idle");
    chk("t5_alu_a_held", {16'b0, u1_a}, 32'h5000);

    // Test 3: ALU_LAT=3 single request, enable and busy lengths.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_slot(2, 16'h0F00, 16'h00F0, 4'h6);
    exp3 = slot_res(2);
    req3 = 4'b0100;
    en_cnt = 0;
    busy_cnt = 0;
    done_at = 0;
    done_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (u3_en) en_cnt++;
      if (u3_busy) busy_cnt++;
      if (u3_done != 4'd0) begin
        done_cnt++;
        done_at = k;
        chk("t3_done_owner", {28'b0, u3_done}, 32'h4);
        chk("t3_result", {16'b0, u3_result}, {16'b0, exp3});
        req3 = 4'b0000;
      end
    end
    chk("t3_en_cycles", en_cnt, 32'd3);
    chk("t3_busy_cycles", busy_cnt, 32'd4);
    chk("t3_done_cycle", done_at, 32'd4);
    chk("t3_done_pulses", done_cnt, 32'd1);

    // Test 4: reset mid-operation; pointer is 3 so 1001 grants requester 3 first.
    req3 = 4'b1001;
    @(negedge clk);
    chk("t4_gnt_before", {28'b0, u3_gnt}, 32'h8);
    @(negedge clk);
    chk("t4_busy_before", {31'b0, u3_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk_zero3("t4_async");
    done_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (u3_done != 4'd0) done_cnt++;
    end
    rst = 1'b0;
    exp3 = slot_res(0);
    @(negedge clk);
    chk("t4_gnt_after", {28'b0, u3_gnt}, 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (u3_done != 4'd0) begin
        chk("t4_done_owner", {28'b0, u3_done}, 32'h1);
        chk("t4_result", {16'b0, u3_result}, {16'b0, exp3});
        req3 = 4'b0000;
      end
    end
    chk("t4_no_done_in_reset", done_cnt, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
